diff_dec: RTL
=============

DIFF_DEC -- requirements
Module: diff_dec

Interface
REQ-001 The module SHALL have parameter SYNC_WORD, default 8'hA7: 8-bit decoded frame-sync pattern, MSB first.
REQ-002 The module SHALL have parameter FRAME_LEN, default 16: payload bits per frame, legal range 1..255.
REQ-003 The module SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 The module SHALL have port enable, input, 1 bit: bit strobe; state advances only on edges where enable=1.
REQ-006 The module SHALL have port in, input, 1 bit: differentially encoded line bit.
REQ-007 The module SHALL have port out, output, 1 bit: decoded payload bit.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out holds a payload bit for this cycle.
REQ-009 The module SHALL have port sync_det, output, 1 bit: one-cycle pulse on sync-word match.
REQ-010 The module SHALL have port frame_end, output, 1 bit: one-cycle pulse coincident with the last payload bit.
REQ-011 The module SHALL have port locked, output, 1 bit: high while in PAYLOAD.
REQ-012 The module SHALL have port frame_cnt, output, 8 bits: completed-frame count (see Configuration).

Function
REQ-013 The module SHALL compute decoded bit d = in XOR prev, where prev is the line bit registered on the previous enabled edge.
REQ-014 On each enabled edge, the module SHALL load prev with in and shift d into the 8-bit register sr, MSB first: sr <= {sr[6:0], d}.
REQ-015 The module SHALL implement two states, SEARCH and PAYLOAD; locked SHALL be 1 exactly when the state is PAYLOAD.
REQ-016 In SEARCH, on an enabled edge where {sr[6:0], d} == SYNC_WORD, the module SHALL go to PAYLOAD, clear bit_cnt to 0, and assert sync_det for the following cycle.
REQ-017 In PAYLOAD, on each enabled edge, the module SHALL register out <= d, set out_valid=1 for the following cycle, and increment bit_cnt.
REQ-018 When bit_cnt == FRAME_LEN-1 on an enabled edge in PAYLOAD, the module SHALL assert frame_end with that last out_valid, return to SEARCH, and clear sr to 0.
REQ-019 Sync bits SHALL never produce out_valid.
REQ-020 A sync pattern appearing inside the payload SHALL be ignored.
REQ-021 The search SHALL restart with the first bit after frame_end, so a back-to-back sync after a frame is detected.
REQ-022 Latency SHALL be one cycle: out, out_valid, sync_det and frame_end reflect the in sampled at the preceding rising edge.
REQ-023 On an edge with enable=0, out_valid, sync_det and frame_end SHALL be 0; prev, sr, state, bit_cnt and out SHALL hold.

Reset
REQ-024 While reset=0, the module SHALL asynchronously clear prev, sr, bit_cnt, out, out_valid, sync_det, frame_end, locked and frame_cnt to 0 and set the state to SEARCH.
REQ-025 A reset asserted mid-frame SHALL discard the partial frame with no frame_end pulse.
REQ-026 The first enabled edge after reset release SHALL decode against prev=0.

Configuration
REQ-027 When macro DIFF_DEC_STATS_EN is defined, frame_cnt SHALL increment on each frame_end and saturate at 255; it clears only on reset.
REQ-028 When DIFF_DEC_STATS_EN is undefined, frame_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-029 Scenario -- reset, enable=1, in=1,1,0,0,0,1,0,1 (encoded A7), then encoded 16'hF00F -> sync_det one cycle after the 8th bit; 16 out_valid cycles with out=1111000000001111; frame_end on the 16th; locked falls after.
REQ-030 Scenario -- as REQ-029 with enable=0 for 5 cycles after payload bit 6 -> no out_valid during the gap; remaining 10 bits correct; frame_end still on decoded bit 16.
REQ-031 Scenario -- reset=0 after payload bit 5 -> all outputs 0 immediately without a clock edge; after release, a fresh encoded A7 locks again.
REQ-032 Scenario -- encoded 8'hA6 and 8'h27 streams -> sync_det and locked stay 0.
REQ-033 Scenario -- payload containing decoded A7, followed immediately by a new encoded A7 after frame_end -> no mid-payload sync_det; second frame locks with no gap cycle.
REQ-034 Scenario -- DIFF_DEC_STATS_EN defined, 3 frames -> frame_cnt=3; 260 frames -> frame_cnt=255; macro undefined -> frame_cnt=0 throughout.

Source files
------------

// File: rtl/diff_dec.sv
// -----------------------------------------------------------------------------
// diff_dec -- differential line decoder with frame synchroniser
//
// Purpose:
//   Recovers data bits from a differentially encoded serial line (a decoded
//   bit is the XOR of the current and previous line bits). It searches the
//   decoded stream for an 8-bit sync word, MSB first. After a match it emits
//   FRAME_LEN payload bits and then resumes the search.
//
// Parameters:
//   SYNC_WORD  8-bit decoded frame-sync pattern, MSB first (default 8'hA7)
//   FRAME_LEN  payload bits per frame, legal range 1..255 (default 16)
//
// Ports:
//   clock      single clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   enable     bit strobe; state advances only on edges where enable=1
//   in         differentially encoded line bit
//   out        decoded payload bit (registered, holds while idle)
//   out_valid  out carries a payload bit this cycle
//   sync_det   one-cycle pulse after the sync word has been matched
//   frame_end  one-cycle pulse coincident with the last payload bit
//   locked     high while the decoder is inside a frame payload
//   frame_cnt  completed-frame count, saturating at 255
//
// Configuration:
//   DIFF_DEC_STATS_EN  when defined, builds the saturating completed-frame
//                      counter. When undefined, frame_cnt is tied to 0 and
//                      no counter logic exists.
//
// Handshake:
//   There is no back-pressure. A bit is accepted on every rising edge where
//   enable=1. The pulse outputs (out_valid, sync_det, frame_end) describe the
//   bit accepted on the previous edge and stay high for exactly one cycle.
//   On an edge with enable=0 they return to 0, and all other state holds.
// -----------------------------------------------------------------------------
module diff_dec #(
    parameter logic [7:0] SYNC_WORD = 8'hA7,
    parameter int         FRAME_LEN = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       in,
    output logic       out,
    output logic       out_valid,
    output logic       sync_det,
    output logic       frame_end,
    output logic       locked,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Index of the final payload bit within a frame.
    localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

    state_t     state_q,     state_d;
    logic       prev_q,      prev_d;
    logic [7:0] sr_q,        sr_d;
    logic [7:0] bit_cnt_q,   bit_cnt_d;
    logic       out_q,       out_d;
    logic       out_valid_q, out_valid_d;
    logic       sync_det_q,  sync_det_d;
    logic       frame_end_q, frame_end_d;

    logic       dec_bit;
    logic [7:0] shifted;

    // The sync compare looks at the register as it will be after this shift.
    // The bit that falls off the top of sr is therefore never read.
    logic       sr_msb_unused;
    assign sr_msb_unused = sr_q[7];

    always_comb begin
        dec_bit     = in ^ prev_q;
        shifted     = {sr_q[6:0], dec_bit};

        state_d     = state_q;
        prev_d      = prev_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_det_d  = 1'b0;
        frame_end_d = 1'b0;

        if (enable) begin
            prev_d = in;
            sr_d   = shifted;
            case (state_q)
                SEARCH: begin
                    // The sync bits are consumed here and never reach out.
                    if (shifted == SYNC_WORD) begin
                        state_d    = PAYLOAD;
                        bit_cnt_d  = 8'd0;
                        sync_det_d = 1'b1;
                    end
                end
                PAYLOAD: begin
                    // Sync patterns inside the payload are not examined.
                    out_d       = dec_bit;
                    out_valid_d = 1'b1;
                    bit_cnt_d   = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Clearing sr makes the search start fresh with the
                        // next bit, so a back-to-back sync is caught.
                        frame_end_d = 1'b1;
                        state_d     = SEARCH;
                        sr_d        = 8'd0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            prev_q      <= 1'b0;
            sr_q        <= 8'd0;
            bit_cnt_q   <= 8'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sync_det_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_det_q  <= sync_det_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef DIFF_DEC_STATS_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Counts on the same edge that raises frame_end. The count holds at 255.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end_d && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sync_det  = sync_det_q;
    assign frame_end = frame_end_q;
    // The state register itself drives locked, so locked is a flop output.
    assign locked    = (state_q == PAYLOAD);

endmodule
